// File: rtl/cm_bit_sequencer.sv
// cm_bit_sequencer: per-bit lookup -> code -> train controller for the CM path.
// Build option: CMSEQ_OVERLAP_EN lets the next lookup overlap the trainer write.
module cm_bit_sequencer #(
  parameter int CM_TW = 20,
  parameter int CM_DW = 32,
  parameter int P_DW  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             table_ready,
  input  logic [7:0]       byte_in,
  input  logic [CM_TW-1:0] cxt_hash,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             byte_done,
  output logic [CM_TW-1:0] lu_cxt,
  output logic             wr_b,
  input  logic [CM_DW-1:0] crcm_in,
  input  logic             crcm_valid,
  output logic [P_DW-1:0]  p_out,
  output logic             bit_out,
  output logic             pb_valid,
  input  logic             pb_ready,
  output logic [CM_TW-1:0] train_cxt,
  output logic             train_y,
  output logic [CM_DW-1:0] train_crcm,
  output logic             train_valid,
  input  logic             train_ready,
  input  logic             train_finish
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT_CM,
    S_CODE,
    S_TRAIN,
    S_WAIT_TRAIN,
    S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [CM_TW-1:0] hash_q, hash_d;
  logic [8:0]       c0_q, c0_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [CM_DW-1:0] cm_q, cm_d;

  logic             byte_ready_q, byte_ready_d;
  logic             byte_done_q, byte_done_d;
  logic [CM_TW-1:0] lu_cxt_q, lu_cxt_d;
  logic             wr_b_q, wr_b_d;
  logic [P_DW-1:0]  p_out_q, p_out_d;
  logic             bit_out_q, bit_out_d;
  logic             pb_valid_q, pb_valid_d;
  logic [CM_TW-1:0] train_cxt_q, train_cxt_d;
  logic             train_y_q, train_y_d;
  logic [CM_DW-1:0] train_crcm_q, train_crcm_d;
  logic             train_valid_q, train_valid_d;

  logic [P_DW-1:0]  p_raw;
  logic [P_DW-1:0]  p_clamp;
  logic [8:0]       c0_nx;

`ifdef CMSEQ_OVERLAP_EN
  logic unused_train_finish;
  assign unused_train_finish = train_finish;
`endif

  // Probability from the entry's top bits; zero is never a legal probability
  always_comb begin
    p_raw   = crcm_in[CM_DW-1 -: P_DW];
    p_clamp = (p_raw == '0) ? P_DW'(1) : p_raw;
    c0_nx   = {c0_q[7:0], bit_out_q};
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    hash_d       = hash_q;
    c0_d         = c0_q;
    bitcnt_d     = bitcnt_q;
    cm_d         = cm_q;
    byte_done_d  = 1'b0;
    lu_cxt_d     = lu_cxt_q;
    p_out_d      = p_out_q;
    bit_out_d    = bit_out_q;
    train_cxt_d  = train_cxt_q;
    train_y_d    = train_y_q;
    train_crcm_d = train_crcm_q;

    unique case (state_q)
      S_IDLE: begin
        if (byte_valid && byte_ready_q) begin
          byte_d   = byte_in;
          hash_d   = cxt_hash;
          c0_d     = 9'd1;
          bitcnt_d = 3'd0;
          lu_cxt_d = cxt_hash + CM_TW'(1);
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_WAIT_CM;
      S_WAIT_CM: begin
        if (crcm_valid) begin
          cm_d      = crcm_in;
          p_out_d   = p_clamp;
          bit_out_d = byte_q[3'd7 - bitcnt_q];
          state_d   = S_CODE;
        end
      end
      S_CODE: begin
        if (pb_ready) begin
          train_cxt_d  = lu_cxt_q;
          train_y_d    = bit_out_q;
          train_crcm_d = cm_q;
          state_d      = S_TRAIN;
        end
      end
      S_TRAIN: begin
        if (train_ready) begin
`ifdef CMSEQ_OVERLAP_EN
          state_d     = S_NEXT;
          byte_done_d = (bitcnt_q == 3'd7);
`else
          state_d     = S_WAIT_TRAIN;
`endif
        end
      end
      S_WAIT_TRAIN: begin
`ifndef CMSEQ_OVERLAP_EN
        if (train_finish) begin
          state_d     = S_NEXT;
          byte_done_d = (bitcnt_q == 3'd7);
        end
`else
        state_d = S_NEXT;
`endif
      end
      S_NEXT: begin
        c0_d     = c0_nx;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          state_d = S_IDLE;
        end else begin
          lu_cxt_d = hash_q + CM_TW'(c0_nx);
          state_d  = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d  = (state_d == S_IDLE) && table_ready;
    wr_b_d        = (state_d == S_LOOKUP);
    pb_valid_d    = (state_d == S_CODE);
    train_valid_d = (state_d == S_TRAIN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_q        <= '0;
      hash_q        <= '0;
      c0_q          <= 9'd1;
      bitcnt_q      <= '0;
      cm_q          <= '0;
      byte_ready_q  <= 1'b0;
      byte_done_q   <= 1'b0;
      lu_cxt_q      <= '0;
      wr_b_q        <= 1'b0;
      p_out_q       <= '0;
      bit_out_q     <= 1'b0;
      pb_valid_q    <= 1'b0;
      train_cxt_q   <= '0;
      train_y_q     <= 1'b0;
      train_crcm_q  <= '0;
      train_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      hash_q        <= hash_d;
      c0_q          <= c0_d;
      bitcnt_q      <= bitcnt_d;
      cm_q          <= cm_d;
      byte_ready_q  <= byte_ready_d;
      byte_done_q   <= byte_done_d;
      lu_cxt_q      <= lu_cxt_d;
      wr_b_q        <= wr_b_d;
      p_out_q       <= p_out_d;
      bit_out_q     <= bit_out_d;
      pb_valid_q    <= pb_valid_d;
      train_cxt_q   <= train_cxt_d;
      train_y_q     <= train_y_d;
      train_crcm_q  <= train_crcm_d;
      train_valid_q <= train_valid_d;
    end
  end

  assign byte_ready  = byte_ready_q;
  assign byte_done   = byte_done_q;
  assign lu_cxt      = lu_cxt_q;
  assign wr_b        = wr_b_q;
  assign p_out       = p_out_q;
  assign bit_out     = bit_out_q;
  assign pb_valid    = pb_valid_q;
  assign train_cxt   = train_cxt_q;
  assign train_y     = train_y_q;
  assign train_crcm  = train_crcm_q;
  assign train_valid = train_valid_q;

endmodule

// File: tb/tb_cm_bit_sequencer.sv
// tb_cm_bit_sequencer: directed bench with simple table and trainer models.
// Build option CMSEQ_OVERLAP_EN selects the overlap expectation.
module tb_cm_bit_sequencer;

  logic        clk;
  logic        rst;
  logic        table_ready;
  logic [7:0]  byte_in;
  logic [19:0] cxt_hash;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_done;
  logic [19:0] lu_cxt;
  logic        wr_b;
  logic [31:0] crcm_in;
  logic        crcm_valid;
  logic [11:0] p_out;
  logic        bit_out;
  logic        pb_valid;
  logic        pb_ready;
  logic [19:0] train_cxt;
  logic        train_y;
  logic [31:0] train_crcm;
  logic        train_valid;
  logic        train_ready;
  logic        train_finish;

  int checks;
  int failures;
  int done_cnt;
  int mem_lat;
  int mcnt;
  int train_lat;
  int tcnt;
  logic [31:0] mem_data;
  logic stray;
  logic wr_in_train;
  logic stable;
  logic [19:0] exp_lu [8];
  logic        exp_bit [8];

  cm_bit_sequencer dut (
    .clk(clk), .rst(rst), .table_ready(table_ready),
    .byte_in(byte_in), .cxt_hash(cxt_hash),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_done(byte_done), .lu_cxt(lu_cxt), .wr_b(wr_b),
    .crcm_in(crcm_in), .crcm_valid(crcm_valid),
    .p_out(p_out), .bit_out(bit_out),
    .pb_valid(pb_valid), .pb_ready(pb_ready),
    .train_cxt(train_cxt), .train_y(train_y),
    .train_crcm(train_crcm), .train_valid(train_valid),
    .train_ready(train_ready), .train_finish(train_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table model: answers each lookup after mem_lat cycles
  always @(negedge clk) begin
    crcm_valid = stray;
    crcm_in = mem_data;
    if (rst) mcnt = 0;
    else if (wr_b) mcnt = mem_lat;
    else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) crcm_valid = 1'b1;
    end
  end

  // Trainer model: busy for train_lat cycles after each request
  always @(negedge clk) begin
    logic hs;
    train_finish = 1'b0;
    hs = train_valid && train_ready;
    if (rst) tcnt = 0;
    else if (hs) tcnt = train_lat;
    else if (tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) train_finish = 1'b1;
    end
    if (wr_b && tcnt > 0) wr_in_train = 1'b1;
    if (!hs) train_ready = (tcnt == 0);
  end

  always @(negedge clk) if (!rst && byte_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: sig = wr_b;
      1: sig = pb_valid;
      2: sig = train_valid;
      3: sig = byte_done;
      default: sig = byte_ready;
    endcase
  endfunction

  task automatic wait_hi(input int s, input string tag);
    int n;
    n = 0;
    while (!sig(s) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({"wait_", tag}, 32'(n < 1000), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [19:0] h);
    wait_hi(4, "ready");
    byte_in = b;
    cxt_hash = h;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic end_byte();
    wait_hi(3, "done");
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bready"}, 32'(byte_ready), 0);
    chk({tag, "_bdone"}, 32'(byte_done), 0);
    chk({tag, "_lu"}, 32'(lu_cxt), 0);
    chk({tag, "_wrb"}, 32'(wr_b), 0);
    chk({tag, "_p"}, 32'(p_out), 0);
    chk({tag, "_bit"}, 32'(bit_out), 0);
    chk({tag, "_pbv"}, 32'(pb_valid), 0);
    chk({tag, "_tcxt"}, 32'(train_cxt), 0);
    chk({tag, "_ty"}, 32'(train_y), 0);
    chk({tag, "_tcrcm"}, train_crcm, 0);
    chk({tag, "_tv"}, 32'(train_valid), 0);
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    mem_lat = 1; train_lat = 1; mcnt = 0; tcnt = 0;
    mem_data = 32'h8000_0000; stray = 1'b0;
    wr_in_train = 1'b0;
    rst = 1'b1; table_ready = 1'b1; byte_valid = 1'b0;
    byte_in = '0; cxt_hash = '0; pb_ready = 1'b1;
    train_ready = 1'b1; train_finish = 1'b0; crcm_valid = 1'b0;
    crcm_in = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst0");
    rst = 1'b0;

    // Byte 0xA5, hash 0x100: c0 runs 1,3,6,D,1A,34,69,D2
    exp_lu = '{20'h00101, 20'h00103, 20'h00106, 20'h0010D,
               20'h0011A, 20'h00134, 20'h00169, 20'h001D2};
    exp_bit = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    send_byte(8'hA5, 20'h00100);
    chk("wrb_at_T1", 32'(wr_b), 1);
    chk("bready_drop", 32'(byte_ready), 0);
    for (int i = 0; i < 8; i++) begin
      wait_hi(0, "wrb");
      chk($sformatf("lu%0d", i), 32'(lu_cxt), 32'(exp_lu[i]));
      wait_hi(1, "pbv");
      chk($sformatf("bit%0d", i), 32'(bit_out), 32'(exp_bit[i]));
      chk($sformatf("p%0d", i), 32'(p_out), 32'h800);
      wait_hi(2, "tv");
      chk($sformatf("tcxt%0d", i), 32'(train_cxt), 32'(exp_lu[i]));
      chk($sformatf("ty%0d", i), 32'(train_y), 32'(exp_bit[i]));
      chk($sformatf("tcrcm%0d", i), train_crcm, 32'h8000_0000);
    end
    end_byte();
    repeat (3) @(negedge clk);
    chk("one_done", 32'(done_cnt), 1);

    // Probability clamp at both ends
    mem_data = 32'h0000_0000;
    send_byte(8'h01, 20'h00010);
    wait_hi(1, "pbv_lo");
    chk("p_clamp_lo", 32'(p_out), 1);
    end_byte();
    mem_data = 32'hFFFF_FFFF;
    send_byte(8'h01, 20'h00010);
    wait_hi(1, "pbv_hi");
    chk("p_clamp_hi", 32'(p_out), 32'hFFF);
    end_byte();

    // Coder back-pressure: outputs held, no train request
    mem_data = 32'h1234_5678;
    pb_ready = 1'b0;
    send_byte(8'h3C, 20'h00200);
    wait_hi(1, "pbv_hold");
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(pb_valid === 1'b1 && p_out === 12'h123 &&
            bit_out === 1'b0 && train_valid === 1'b0))
        stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 1);
    chk("hold_p", 32'(p_out), 32'h123);
    pb_ready = 1'b1;
    wait_hi(2, "tv_hold");
    chk("hold_tcxt", 32'(train_cxt), 32'h00201);
    chk("hold_ty", 32'(train_y), 0);
    chk("hold_tcrcm", train_crcm, 32'h1234_5678);
    end_byte();

    // Index wrap
    send_byte(8'h80, 20'hFFFFF);
    chk("wrap0", 32'(lu_cxt), 0);
    @(negedge clk);
    wait_hi(0, "wrb_wrap1");
    chk("wrap1", 32'(lu_cxt), 2);
    end_byte();

    // Slow trainer: lookups vs outstanding training
    train_lat = 20;
    wr_in_train = 1'b0;
    send_byte(8'h00, 20'h00300);
    end_byte();
`ifdef CMSEQ_OVERLAP_EN
    chk("wr_during_train", 32'(wr_in_train), 1);
`else
    chk("wr_during_train", 32'(wr_in_train), 0);
`endif
    repeat (25) @(negedge clk);
    train_lat = 1;
    chk("done_total", 32'(done_cnt), 6);

    // Reset while waiting for the table
    mem_lat = 40;
    send_byte(8'h55, 20'h00400);
    @(negedge clk);
    rst = 1'b1;
    table_ready = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst1");
    rst = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_pbv", 32'(pb_valid), 0);
    chk("stray_bready", 32'(byte_ready), 0);
    table_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bready_back", 32'(byte_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
